// File: rtl/pattern_detector_mealy.sv
// rtl/pattern_detector_mealy.sv - Mealy serial pattern detector with KMP fallback and saturating match counter
//
// Purpose: detects PATTERN (first-received bit is PATTERN[PAT_LEN-1]) in a
// qualified serial bit stream, in overlapping or non-overlapping mode.
// Optional feature macro: PATTERN_DETECTOR_STICKY_EN (registered hit_sticky flag).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    qualifies in_bit this cycle
//   in_bit      serial data bit
//   overlap     1 = overlapping detection, 0 = restart after each match
//   clear       synchronous clear of state, counter and sticky flag
//   match       combinational Mealy detect pulse
//   match_count saturating number of matches
//   state_dbg   current matched-prefix length
//   hit_sticky  sticky detect flag (0 when the feature macro is undefined)

module pattern_detector_mealy #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             overlap,
   input  logic             clear,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic [4:0]       state_dbg,
   output logic             hit_sticky
);

   localparam logic [4:0] LAST = 5'(PAT_LEN - 1);

   // Longest pattern prefix (capped at PAT_LEN-1) that is a suffix of
   // "first s pattern bits followed by b". Scanning k upward and keeping the
   // last hit yields the longest one. For s = PAT_LEN-1 with the final pattern
   // bit this is the longest proper border, i.e. the overlapping restart point.
   function automatic logic [4:0] kmp_next(input int s, input logic b);
      logic [4:0] res;
      logic       ok;
      logic       cand;
      int         idx;
      res = 5'd0;
      for (int k = 1; k <= s + 1; k++) begin
         if (k < PAT_LEN) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
               idx  = s + 1 - k + j;
               cand = (idx == s) ? b : PATTERN[PAT_LEN-1-idx];
               if (cand != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
            end
            if (ok) res = 5'(k);
         end
      end
      return res;
   endfunction

   logic [4:0]       state;
   logic [4:0]       state_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic [4:0]       fb;
   logic             match_i;

   // Elaboration-time transition tables, one entry per prefix length.
   logic [4:0] nxt0 [PAT_LEN];
   logic [4:0] nxt1 [PAT_LEN];

   genvar g;
   for (g = 0; g < PAT_LEN; g++) begin : g_tbl
      assign nxt0[g] = kmp_next(g, 1'b0);
      assign nxt1[g] = kmp_next(g, 1'b1);
   end

   always_comb begin
      fb = 5'd0;
      for (int i = 0; i < PAT_LEN; i++) begin
         if (state == 5'(i)) fb = in_bit ? nxt1[i] : nxt0[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= 5'd0;
         match_count <= '0;
      end else begin
         state       <= state_nx;
         match_count <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = match_count;
      match_i  = 1'b0;
      if (clear) begin
         state_nx = 5'd0;
         cnt_nx   = '0;
      end else if (in_valid) begin
         if ((state == LAST) && (in_bit == PATTERN[0])) begin
            match_i  = 1'b1;
            state_nx = overlap ? fb : 5'd0;
            if (match_count != {CNT_W{1'b1}}) cnt_nx = match_count + CNT_W'(1);
         end else begin
            state_nx = fb;
         end
      end
   end

   // Reset gating keeps match quiet for the whole reset interval.
   assign match     = match_i & ~reset;
   assign state_dbg = state;

`ifdef PATTERN_DETECTOR_STICKY_EN
   logic sticky_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        sticky_q <= 1'b0;
      else if (clear)   sticky_q <= 1'b0;
      else if (match_i) sticky_q <= 1'b1;
   end

   assign hit_sticky = sticky_q;
`else
   assign hit_sticky = 1'b0;
`endif

endmodule
